bip_alu_datapath: RTL and testbench

Accumulator datapath for the next-generation BIP core. It extends the single add/subtract accumulator with an 8-operation ALU, registered status flags and a multi-cycle shift-add multiplier. It sits between the control unit (which supplies operand selects, opcode and write strobe, and stalls on `o_busy`) and the data memory (`o_data` is the accumulator, used as the store value). Width and immediate size are parametrised.

---
 rtl/bip_alu_datapath.sv | 171 +++++++++++++++++
 tb/tb_bip_alu_datapath.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bip_alu_datapath.sv
// BIP accumulator datapath: 8-op ALU, registered Z/N/C/V flags and an
// iterative shift-add multiplier that stalls the control unit via o_busy.
module bip_alu_datapath #(
    parameter int NB_DATA = 16,
    parameter int NB_IMM  = 11
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_data_mem,
    input  logic [NB_IMM-1:0]  i_imm,
    input  logic [1:0]         i_sel_a,
    input  logic               i_sel_b,
    input  logic [2:0]         i_op,
    input  logic               i_wr_acc,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_zero,
    output logic               o_neg,
    output logic               o_carry,
    output logic               o_ovf,
    output logic               o_busy
);
    localparam int NB_SH  = $clog2(NB_DATA);
    localparam int NB_CNT = $clog2(NB_DATA + 1);
    localparam int MSB    = NB_DATA - 1;

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [NB_DATA-1:0] r_acc;
    logic                      r_zero, r_neg, r_carry, r_ovf;
    logic signed [NB_DATA-1:0] r_mcand, r_mplier, r_prod;
    logic [NB_CNT-1:0]         r_cnt;

    logic signed [NB_IMM-1:0]  w_imm_s;
    logic signed [NB_DATA-1:0] w_imm_x, w_b, w_alu, w_acc_d, w_prod_next;
    logic [NB_DATA:0]          w_sum;
    logic [NB_SH-1:0]          w_shamt;
    logic                      w_carry, w_ovf, w_acc_we, w_cv_we, w_mul_start;

    assign w_imm_s     = i_imm;
    assign w_imm_x     = NB_DATA'(w_imm_s);
    assign w_b         = i_sel_b ? w_imm_x : i_data_mem;
    assign w_shamt     = w_b[NB_SH-1:0];
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_sum   = '0;
        w_alu   = '0;
        w_carry = r_carry;
        w_ovf   = r_ovf;
        case (i_op)
            OP_SUB: begin
                w_sum   = {1'b0, r_acc} + {1'b0, ~w_b} + {{NB_DATA{1'b0}}, 1'b1};
                w_alu   = w_sum[NB_DATA-1:0];
                w_carry = w_sum[NB_DATA];
                w_ovf   = (r_acc[MSB] != w_b[MSB]) && (w_alu[MSB] != r_acc[MSB]);
            end
            OP_ADD: begin
                w_sum   = {1'b0, r_acc} + {1'b0, w_b};
                w_alu   = w_sum[NB_DATA-1:0];
                w_carry = w_sum[NB_DATA];
                w_ovf   = (r_acc[MSB] == w_b[MSB]) && (w_alu[MSB] != r_acc[MSB]);
            end
            OP_AND:  w_alu = r_acc & w_b;
            OP_OR:   w_alu = r_acc | w_b;
            OP_XOR:  w_alu = r_acc ^ w_b;
            OP_SLL:  w_alu = r_acc << w_shamt;
            OP_SRA:  w_alu = r_acc >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Write decode and FSM next state; strobes are dropped while in ST_MUL
    always_comb begin
        w_state_next = r_state;
        w_acc_we     = 1'b0;
        w_acc_d      = r_acc;
        w_cv_we      = 1'b0;
        w_mul_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_wr_acc) begin
                    case (i_sel_a)
                        2'b00: begin
                            w_acc_we = 1'b1;
                            w_acc_d  = i_data_mem;
                        end
                        2'b01: begin
                            w_acc_we = 1'b1;
                            w_acc_d  = w_imm_x;
                        end
                        2'b10: begin
                            if (i_op == OP_MUL) begin
                                w_mul_start  = 1'b1;
                                w_state_next = ST_MUL;
                            end else begin
                                w_acc_we = 1'b1;
                                w_acc_d  = w_alu;
                                w_cv_we  = (i_op == OP_ADD) || (i_op == OP_SUB);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (r_cnt == NB_CNT'(NB_DATA - 1)) begin
                    w_acc_we     = 1'b1;
                    w_acc_d      = w_prod_next;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_acc_we) begin
                r_acc  <= w_acc_d;
                r_zero <= (w_acc_d == '0);
                r_neg  <= w_acc_d[MSB];
            end
            if (w_cv_we) begin
                r_carry <= w_carry;
                r_ovf   <= w_ovf;
            end
        end
    end

    // Multiplier iteration registers; fully reloaded on every start
    always_ff @(negedge i_clk) begin
        if (w_mul_start) begin
            r_mcand  <= r_acc;
            r_mplier <= w_b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_MUL) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + NB_CNT'(1);
        end
    end

    assign o_data  = r_acc;
    assign o_zero  = r_zero;
    assign o_neg   = r_neg;
    assign o_carry = r_carry;
    assign o_ovf   = r_ovf;
    assign o_busy  = (r_state == ST_MUL);

endmodule

// File: tb/tb_bip_alu_datapath.sv
// Directed-vector bench for bip_alu_datapath (NB_DATA=16, NB_IMM=11).
// Inputs change on the rising edge; outputs are sampled one rising edge later.
module tb_bip_alu_datapath;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_data_mem;
    logic [10:0] i_imm;
    logic [1:0]  i_sel_a;
    logic        i_sel_b;
    logic [2:0]  i_op;
    logic        i_wr_acc;
    logic [15:0] o_data;
    logic        o_zero, o_neg, o_carry, o_ovf, o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bip_alu_datapath #(.NB_DATA(16), .NB_IMM(11)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data_mem(i_data_mem), .i_imm(i_imm),
        .i_sel_a(i_sel_a), .i_sel_b(i_sel_b), .i_op(i_op), .i_wr_acc(i_wr_acc),
        .o_data(o_data), .o_zero(o_zero), .o_neg(o_neg), .o_carry(o_carry),
        .o_ovf(o_ovf), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n,
                               input logic c, input logic v);
        check(tag, {28'd0, o_zero, o_neg, o_carry, o_ovf}, {28'd0, z, n, c, v});
    endtask

    task automatic drive(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                         input logic [15:0] mem, input logic [10:0] imm, input logic wr);
        i_sel_a = sa; i_sel_b = sb; i_op = op; i_data_mem = mem; i_imm = imm; i_wr_acc = wr;
        @(posedge i_clk);
        i_wr_acc = 1'b0;
    endtask

    task automatic load_mem(input logic [15:0] v);
        drive(2'b00, 1'b0, 3'b000, v, 11'd0, 1'b1);
    endtask

    task automatic load_imm(input logic [10:0] v);
        drive(2'b01, 1'b0, 3'b000, 16'd0, v, 1'b1);
    endtask

    task automatic alu_imm(input logic [2:0] op, input logic [10:0] v);
        drive(2'b10, 1'b1, op, 16'd0, v, 1'b1);
    endtask

    task automatic alu_mem(input logic [2:0] op, input logic [15:0] v);
        drive(2'b10, 1'b0, op, v, 11'd0, 1'b1);
    endtask

    initial begin
        int   busy_cycles;
        logic held;

        i_rst = 1'b1; i_data_mem = '0; i_imm = '0; i_sel_a = 2'b01;
        i_sel_b = 1'b0; i_op = '0; i_wr_acc = 1'b1;
        i_imm = 11'd5;
        repeat (2) @(posedge i_clk);
        check("rst_data", {16'd0, o_data}, 32'h0);
        check_flags("rst_flags", 0, 0, 0, 0);
        check("rst_busy", {31'd0, o_busy}, 32'h0);
        i_rst = 1'b0; i_wr_acc = 1'b0;

        load_imm(11'h7FF);
        check("imm_7ff", {16'd0, o_data}, 32'hFFFF);
        check_flags("imm_7ff_fl", 0, 1, 0, 0);
        load_imm(11'h3FF);
        check("imm_3ff", {16'd0, o_data}, 32'h03FF);
        check_flags("imm_3ff_fl", 0, 0, 0, 0);

        load_mem(16'h7FFF);
        alu_imm(3'b001, 11'd1);
        check("add_ovf", {16'd0, o_data}, 32'h8000);
        check_flags("add_ovf_fl", 0, 1, 0, 1);
        load_mem(16'hFFFF);
        alu_mem(3'b001, 16'h0001);
        check("add_carry", {16'd0, o_data}, 32'h0000);
        check_flags("add_carry_fl", 1, 0, 1, 0);

        load_mem(16'h0005);
        alu_mem(3'b000, 16'h0005);
        check("sub_zero", {16'd0, o_data}, 32'h0000);
        check_flags("sub_zero_fl", 1, 0, 1, 0);
        load_mem(16'h8000);
        alu_imm(3'b000, 11'd1);
        check("sub_ovf", {16'd0, o_data}, 32'h7FFF);
        check_flags("sub_ovf_fl", 0, 0, 1, 1);

        // C=1, V=1 from here; logic and shift ops must preserve them
        load_mem(16'h8000);
        alu_imm(3'b110, 11'd4);
        check("sra", {16'd0, o_data}, 32'hF800);
        check_flags("sra_fl", 0, 1, 1, 1);
        load_imm(11'd1);
        alu_imm(3'b101, 11'd15);
        check("sll", {16'd0, o_data}, 32'h8000);
        check_flags("sll_fl", 0, 1, 1, 1);
        load_mem(16'hF0F0);
        alu_mem(3'b100, 16'hFFFF);
        check("xor", {16'd0, o_data}, 32'h0F0F);
        check_flags("xor_fl", 0, 0, 1, 1);
        alu_mem(3'b010, 16'h00FF);
        check("and", {16'd0, o_data}, 32'h000F);
        alu_imm(3'b011, 11'h0F0);
        check("or", {16'd0, o_data}, 32'h00FF);
        alu_imm(3'b000, 11'h0FF);
        check("sub_to_zero", {16'd0, o_data}, 32'h0000);
        check_flags("sub_to_zero_fl", 1, 0, 1, 0);

        drive(2'b01, 1'b0, 3'b000, 16'd0, 11'h123, 1'b0);
        check("wr0_hold", {16'd0, o_data}, 32'h0000);
        drive(2'b11, 1'b0, 3'b000, 16'h5555, 11'h123, 1'b1);
        check("sel11_hold", {16'd0, o_data}, 32'h0000);
        check_flags("sel11_fl", 1, 0, 1, 0);

        load_imm(11'h7FD);
        check("mul_a", {16'd0, o_data}, 32'hFFFD);
        alu_imm(3'b111, 11'd7);
        busy_cycles = 0;
        held = 1'b1;
        for (int k = 0; k < 40 && o_busy; k++) begin
            busy_cycles++;
            if (o_data !== 16'hFFFD) held = 1'b0;
            if (k == 3) drive(2'b01, 1'b0, 3'b000, 16'd0, 11'h123, 1'b1);
            else        drive(2'b11, 1'b0, 3'b000, 16'd0, 11'd0, 1'b0);
        end
        check("mul_busy_cycles", busy_cycles, 32'd16);
        check("mul_data_held", {31'd0, held}, 32'h1);
        check("mul_result", {16'd0, o_data}, 32'hFFEB);
        check_flags("mul_fl", 0, 1, 1, 0);
        alu_imm(3'b001, 11'd2);
        check("after_mul_add", {16'd0, o_data}, 32'hFFED);

        load_imm(11'h7FF);
        alu_imm(3'b111, 11'd3);
        check("mul2_busy", {31'd0, o_busy}, 32'h1);
        repeat (7) drive(2'b11, 1'b0, 3'b000, 16'd0, 11'd0, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk);
        check("midrst_data", {16'd0, o_data}, 32'h0);
        check_flags("midrst_fl", 0, 0, 0, 0);
        check("midrst_busy", {31'd0, o_busy}, 32'h0);
        i_rst = 1'b0;
        alu_imm(3'b001, 11'd2);
        check("post_rst_add", {16'd0, o_data}, 32'h0002);
        repeat (20) @(posedge i_clk);
        check("post_rst_stable", {16'd0, o_data}, 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
